// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, default reset address, default increment.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_RST_ADDR_DEF   = 32'h0000_0000;
    localparam int unsigned PC_INST_BYTES_DEF = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, replace-top and clear.
// Latency: top-of-stack is combinational from registered state; updates land next cycle.
// Backpressure: none; a push when full silently overwrites the oldest entry.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_clr                    drop all entries (wins over push/pop)
//   i_push, i_pop            push and pop together replace the top entry
//   i_push_dat               address pushed / written over the top
//   o_top, o_empty, o_full   current top entry and occupancy flags
module pc_ras #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_dat,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_empty,
    output logic              o_full
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_ptr;        // index of the current top entry
    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  w_ptr_inc;
    logic [PTR_W-1:0]  w_ptr_dec;
    logic [PTR_W-1:0]  w_wr_ptr;
    logic              w_replace;
    logic              w_pop_only;
    logic              w_push_only;

    // Explicit wrap so DEPTH need not be a power of two.
    assign w_ptr_inc = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_dec = (r_ptr == '0) ? PTR_LAST : r_ptr - PTR_W'(1);

    assign o_top   = r_mem[r_ptr];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CNT_FULL);

    // Pop on an empty stack is meaningless; a push+pop there degrades to a push.
    assign w_replace   = i_push && i_pop && !o_empty;
    assign w_push_only = i_push && !w_replace;
    assign w_pop_only  = i_pop && !i_push && !o_empty;
    assign w_wr_ptr    = w_replace ? r_ptr : w_ptr_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_push_only) begin
            // When full, the slot after the top is the oldest entry, so
            // advancing the pointer overwrites it and the count saturates.
            r_ptr <= w_ptr_inc;
            if (!o_full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (w_pop_only) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only read while the count covers them.
    always_ff @(posedge clk) begin
        if (!rst && !i_clr && i_push) begin
            r_mem[w_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: trap > jump > return prediction > hold > increment.
// Latency: one cycle from redirect/accept to the new pc_o; flush_o pulses the cycle after a redirect.
// Backpressure: pc_o holds while pc_ready_i is low or hold_i is high; redirects ignore both.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   trap_en_i/trap_addr_i              trap redirect (clears the return stack)
//   jmp_en_i/jmp_addr_i                resolved jump redirect
//   hold_i, halt_i                     stall, request to enter HALT
//   call_i, ret_i                      predecode of the instruction at pc_o
//   pc_o, pc_valid_o, pc_ready_i       fetch address handshake
//   flush_o, halted_o                  redirect pulse, HALT indicator
// Optional feature: define PC_RAS_EN to build the return-address stack.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] RST_ADDR   = PC_RST_ADDR_DEF,
    parameter int unsigned INST_BYTES = PC_INST_BYTES_DEF,
    parameter int unsigned RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_en_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              jmp_en_i,
    input  logic [ADDR_W-1:0] jmp_addr_i,
    input  logic              hold_i,
    input  logic              halt_i,
    input  logic              call_i,
    input  logic              ret_i,
    input  logic              pc_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              flush_o,
    output logic              halted_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

    pc_state_t         r_state;
    pc_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_redir_tgt;
    logic [ADDR_W-1:0] w_ras_top;
    logic              r_flush;
    logic              w_valid;
    logic              w_accept;
    logic              w_redirect;
    logic              w_ras_empty;
    logic              w_ras_pop;

    assign w_valid    = (r_state == ST_RUN);
    assign w_accept   = w_valid && pc_ready_i && !hold_i;
    assign w_redirect = trap_en_i || jmp_en_i;
    assign w_pc_seq   = r_pc + PC_STEP;   // wraps modulo 2^ADDR_W
    assign w_redir_tgt = (trap_en_i ? trap_addr_i : jmp_addr_i) & ~ALIGN_MASK;

    // A return only predicts when there is something to pop; otherwise it
    // falls through to the sequential address.
    assign w_ras_pop = w_accept && ret_i && !w_redirect && !w_ras_empty;

`ifdef PC_RAS_EN
    logic w_ras_push;
    logic w_ras_full;

    assign w_ras_push = w_accept && call_i && !w_redirect;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (trap_en_i),
        .i_push     (w_ras_push),
        .i_pop      (w_ras_pop),
        .i_push_dat (w_pc_seq),
        .o_top      (w_ras_top),
        .o_empty    (w_ras_empty),
        .o_full     (w_ras_full)
    );

    logic w_unused_full;
    assign w_unused_full = w_ras_full;
`else
    // Without the stack a return never predicts and calls have no consumer.
    localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
    logic w_unused_call;
    assign w_unused_call = call_i;
    assign w_ras_empty   = 1'b1;
    assign w_ras_top     = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;

        unique case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  if (halt_i && !w_redirect) w_state_nxt = ST_HALT;
            ST_HALT: if (w_redirect) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase

        if (w_redirect) begin
            w_pc_nxt = w_redir_tgt;
        end else if (w_ras_pop) begin
            w_pc_nxt = w_ras_top;
        end else if (w_accept) begin
            w_pc_nxt = w_pc_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= ADDR_W'(RST_ADDR);
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flush <= w_redirect;
        end
    end

    assign pc_o       = r_pc;
    assign pc_valid_o = w_valid;
    assign flush_o    = r_flush;
    assign halted_o   = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_pc_gen;

    localparam logic [31:0] RST_A = 32'h8000_0000;
    localparam int          DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_en_i, jmp_en_i, hold_i, halt_i, call_i, ret_i, pc_ready_i;
    logic [31:0] trap_addr_i, jmp_addr_i;
    logic [31:0] pc_o;
    logic        pc_valid_o, flush_o, halted_o;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W     (32),
        .RST_ADDR   (RST_A),
        .INST_BYTES (4),
        .RAS_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trap_en_i   (trap_en_i),
        .trap_addr_i (trap_addr_i),
        .jmp_en_i    (jmp_en_i),
        .jmp_addr_i  (jmp_addr_i),
        .hold_i      (hold_i),
        .halt_i      (halt_i),
        .call_i      (call_i),
        .ret_i       (ret_i),
        .pc_ready_i  (pc_ready_i),
        .pc_o        (pc_o),
        .pc_valid_o  (pc_valid_o),
        .flush_o     (flush_o),
        .halted_o    (halted_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: flags for "still booting" / "halted", a plain PC, and
    // the return stack as a queue whose back is the most recent call.
    logic [31:0] m_pc;
    bit          m_boot, m_halt, m_flush;
    logic [31:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit          running, accept, redirect;
        logic [31:0] seq, top;
        running  = !m_boot && !m_halt;
        accept   = running && pc_ready_i && !hold_i;
        redirect = trap_en_i || jmp_en_i;
        seq      = m_pc + 32'd4;
        if (rst) begin
            m_pc = RST_A; m_boot = 1; m_halt = 0; m_flush = 0;
            m_ras.delete();
        end else begin
            m_flush = redirect;
            if (trap_en_i) begin
                m_pc = {trap_addr_i[31:2], 2'b00};
                m_ras.delete();
            end else if (jmp_en_i) begin
                m_pc = {jmp_addr_i[31:2], 2'b00};
            end else if (accept) begin
                if (RAS_ON && ret_i && m_ras.size() > 0) begin
                    top = m_ras[$];
                    if (call_i) m_ras[$] = seq;
                    else void'(m_ras.pop_back());
                    m_pc = top;
                end else begin
                    if (RAS_ON && call_i) begin
                        m_ras.push_back(seq);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
                    m_pc = seq;
                end
            end
            if (redirect) begin
                m_boot = 0; m_halt = 0;
            end else if (m_boot) begin
                m_boot = 0;
            end else if (running && halt_i) begin
                m_halt = 1;
            end
        end
    endtask

    // Inputs are stable around the rising edge; outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("pc", pc_o, m_pc);
        chk("valid", 32'(pc_valid_o), 32'(!m_boot && !m_halt));
        chk("flush", 32'(flush_o), 32'(m_flush));
        chk("halted", 32'(halted_o), 32'(m_halt));
    endtask

    task automatic idle_ctl();
        trap_en_i = 0; jmp_en_i = 0; hold_i = 0; halt_i = 0; call_i = 0; ret_i = 0;
    endtask

    task automatic jump(input logic [31:0] a);
        jmp_en_i = 1; jmp_addr_i = a;
        step();
        jmp_en_i = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else a = $urandom;
        return a;
    endfunction

    initial begin
        rst = 1; pc_ready_i = 1; trap_addr_i = 0; jmp_addr_i = 0;
        idle_ctl();
        m_pc = 0; m_boot = 1; m_halt = 0; m_flush = 0;
        @(negedge clk);
        step(); step();
        chk("rst_pc", pc_o, RST_A);
        chk("rst_valid", 32'(pc_valid_o), 0);
        chk("rst_flush", 32'(flush_o), 0);
        chk("rst_halted", 32'(halted_o), 0);

        // Boot then zero-bubble streaming.
        rst = 0;
        step(); chk("boot_pc0", pc_o, 32'h8000_0000); chk("boot_valid", 32'(pc_valid_o), 1);
        step(); chk("stream_pc1", pc_o, 32'h8000_0004);
        step(); chk("stream_pc2", pc_o, 32'h8000_0008);

        // Hold and ready stalls.
        jump(32'h10);
        hold_i = 1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("hold_pc", pc_o, 32'h10);
        end
        chk("hold_flush", 32'(flush_o), 0);
        hold_i = 0; pc_ready_i = 0;
        step(); step(); chk("nrdy_pc", pc_o, 32'h10);
        pc_ready_i = 1;
        step(); chk("release_pc", pc_o, 32'h14);

        // Trap beats jump, ignores hold; flush lasts one cycle; alignment.
        trap_en_i = 1; trap_addr_i = 32'h100; jmp_en_i = 1; jmp_addr_i = 32'h200; hold_i = 1;
        step(); chk("trap_pc", pc_o, 32'h100); chk("trap_flush", 32'(flush_o), 1);
        trap_en_i = 0; jmp_en_i = 0;
        step(); chk("flush_drop", 32'(flush_o), 0);
        hold_i = 0;
        jump(32'h203); chk("align_pc", pc_o, 32'h200);

        // Wrap, halt, wake on jump.
        jump(32'hFFFF_FFFC);
        step(); chk("wrap_pc", pc_o, 32'h0);
        halt_i = 1;
        step(); chk("halt_flag", 32'(halted_o), 1); chk("halt_valid", 32'(pc_valid_o), 0);
        halt_i = 0;
        step(); chk("halt_stay", 32'(halted_o), 1);
        jump(32'h40); chk("wake_pc", pc_o, 32'h40); chk("wake_halted", 32'(halted_o), 0);

        // Return-address stack scenarios.
        jump(32'h20);
        call_i = 1; step(); call_i = 0;
        step(); step();
        ret_i = 1; step(); ret_i = 0;
        if (RAS_ON) chk("ras_ret", pc_o, 32'h24);
        chk("ras_noflush", 32'(flush_o), 0);

        jump(32'h1000);
        call_i = 1;
        for (int i = 0; i < 5; i++) step();
        call_i = 0; ret_i = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (RAS_ON) chk("ras_pop", pc_o, (i < 4) ? 32'h1014 - 32'(4 * i) : 32'h100C);
        end
        ret_i = 0;
        call_i = 1; step(); call_i = 0;
        trap_en_i = 1; trap_addr_i = 32'h300; step(); trap_en_i = 0;
        ret_i = 1; step(); ret_i = 0;
        chk("trap_clears_ras", pc_o, 32'h304);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            trap_en_i  = ($urandom_range(0, 29) == 0);
            jmp_en_i   = ($urandom_range(0, 14) == 0);
            hold_i     = ($urandom_range(0, 4) == 0);
            halt_i     = ($urandom_range(0, 19) == 0);
            pc_ready_i = ($urandom_range(0, 3) != 0);
            call_i     = ($urandom_range(0, 5) == 0);
            ret_i      = ($urandom_range(0, 5) == 0);
            trap_addr_i = rnd_addr();
            jmp_addr_i  = rnd_addr();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
